// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback for LW, SW, J, JAL, JR,
// BNE, XORI, ADD, SUB and SLT, and stalls on the unified memory.
//
// Memory handshake: a request (mem_read_enable or mem_write_enable) is held
// steady, together with its address select, until the cycle in which
// mem_ready=1; that cycle is the one in which the access completes, so
// pc_write, ir_write and the store's instr_done are qualified by mem_ready.
// mem_ready is ignored in every state that does not issue a request.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read_enable,
    output logic       mem_write_enable,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write_enable,
    output logic [1:0] reg_dest,
    output logic [1:0] mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JAL       = 4'd13,
        JR        = 4'd14
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    state_t cur_state;
    state_t nxt_state;
    logic   illegal_q;
    logic   decode_bad;

    // The zero flag gates pc_write_cond inside the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    assign state   = cur_state;
    assign illegal = illegal_q;

    // State register and sticky illegal flag; only reset clears either.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == DECODE && decode_bad)
                illegal_q <= 1'b1;
        end
    end

    // Next-state logic; DECODE dispatches on the live op/funct from IR.
    always_comb begin
        nxt_state  = cur_state;
        decode_bad = 1'b0;
        case (cur_state)
            IDLE:      nxt_state = FETCH;
            FETCH:     nxt_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    6'h23, 6'h2B: nxt_state = MEM_ADDR;
                    6'h00: begin
                        if (funct == 6'h20 || funct == 6'h22 || funct == 6'h2A)
                            nxt_state = R_EXEC;
                        else if (funct == 6'h08)
                            nxt_state = JR;
                        else begin
                            nxt_state  = FETCH;
                            decode_bad = 1'b1;
                        end
                    end
                    6'h0E: nxt_state = I_EXEC;
                    6'h05: nxt_state = BRANCH;
                    6'h02: nxt_state = JUMP;
                    6'h03: nxt_state = JAL;
                    default: begin
                        nxt_state  = FETCH;
                        decode_bad = 1'b1;
                    end
                endcase
            end
            MEM_ADDR:  nxt_state = (op == 6'h23) ? MEM_READ : MEM_WRITE;
            MEM_READ:  nxt_state = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: nxt_state = mem_ready ? FETCH : MEM_WRITE;
            R_EXEC:    nxt_state = R_WB;
            I_EXEC:    nxt_state = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, JR: nxt_state = FETCH;
            default:   nxt_state = IDLE;
        endcase
    end

    // Moore output decode; only fetch and store completion look at mem_ready.
    always_comb begin
        pc_write         = 1'b0;
        pc_write_cond    = 1'b0;
        pc_src           = 2'd0;
        i_or_d           = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        ir_write         = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = 3'd0;
        alu_op           = ALU_ADD;
        reg_write_enable = 1'b0;
        reg_dest         = 2'd0;
        mem_to_reg       = 2'd0;
        instr_done       = 1'b0;
        case (cur_state)
            FETCH: begin
                mem_read_enable = 1'b1;
                alu_src_b       = 3'd1;
                pc_write        = mem_ready;
                ir_write        = mem_ready;
            end
            DECODE:   alu_src_b = 3'd3;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 3'd2;
            end
            MEM_READ: begin
                i_or_d          = 1'b1;
                mem_read_enable = 1'b1;
            end
            MEM_WB: begin
                reg_write_enable = 1'b1;
                mem_to_reg       = 2'd1;
                instr_done       = 1'b1;
            end
            MEM_WRITE: begin
                i_or_d           = 1'b1;
                mem_write_enable = 1'b1;
                instr_done       = mem_ready;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'h22:   alu_op = ALU_SUB;
                    6'h2A:   alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            R_WB: begin
                reg_write_enable = 1'b1;
                reg_dest         = 2'd1;
                instr_done       = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 3'd4;
                alu_op    = ALU_XOR;
            end
            I_WB: begin
                reg_write_enable = 1'b1;
                instr_done       = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
                instr_done    = 1'b1;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'd2;
                instr_done = 1'b1;
            end
            JAL: begin
                pc_write         = 1'b1;
                pc_src           = 2'd2;
                reg_write_enable = 1'b1;
                reg_dest         = 2'd2;
                mem_to_reg       = 2'd2;
                instr_done       = 1'b1;
            end
            JR: begin
                pc_write   = 1'b1;
                pc_src     = 2'd3;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction streams with random memory
// stalls; a reference model expands each instruction into its expected
// per-cycle control word and a monitor compares every cycle.
module tb_multicycle_control;

    localparam int W = 26;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dest;
        logic [1:0] mem_to_reg;
        logic       instr_done;
        logic       illegal;
        logic [3:0] state;
    } ctl_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read_enable, mem_write_enable;
    logic       ir_write, alu_src_a, reg_write_enable, instr_done, illegal;
    logic [1:0] pc_src, reg_dest, mem_to_reg;
    logic [2:0] alu_src_b, alu_op;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .i_or_d(i_or_d), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .ir_write(ir_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write_enable(reg_write_enable), .reg_dest(reg_dest),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   model_illegal = 1'b0;
    logic [5:0] cur_op = '0;
    logic [5:0] cur_funct = '0;

    // Control word each step of an instruction asks for, with fetch and
    // store completion shown in their mem_ready=1 form.
    function automatic ctl_t step_ctl(input int st);
        ctl_t c = '0;
        case (st)
            1:  begin c.mem_read = 1; c.alu_src_b = 1; c.pc_write = 1; c.ir_write = 1; end
            2:  c.alu_src_b = 3;
            3:  begin c.alu_src_a = 1; c.alu_src_b = 2; end
            4:  begin c.i_or_d = 1; c.mem_read = 1; end
            5:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
            6:  begin c.i_or_d = 1; c.mem_write = 1; c.instr_done = 1; end
            7:  c.alu_src_a = 1;
            8:  begin c.reg_write = 1; c.reg_dest = 1; c.instr_done = 1; end
            9:  begin c.alu_src_a = 1; c.alu_src_b = 4; c.alu_op = 3'b010; end
            10: begin c.reg_write = 1; c.instr_done = 1; end
            11: begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1;
                      c.pc_src = 1; c.instr_done = 1; end
            12: begin c.pc_write = 1; c.pc_src = 2; c.instr_done = 1; end
            13: begin c.pc_write = 1; c.pc_src = 2; c.reg_write = 1; c.reg_dest = 2;
                      c.mem_to_reg = 2; c.instr_done = 1; end
            14: begin c.pc_write = 1; c.pc_src = 3; c.instr_done = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        if (f == 6'h22) return 3'b001;
        if (f == 6'h2A) return 3'b011;
        return 3'b000;
    endfunction

    // ---------------- driver ----------------
    // One clock of stimulus; the matching expected word goes on the queue.
    task automatic drive_cycle(input int st, input bit mr, input bit rst);
        ctl_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = mr;
        zero      = 1'($urandom_range(0, 1));
        op        = cur_op;
        funct     = cur_funct;
        if (rst) begin
            model_illegal = 1'b0;
            e = '0;
        end else begin
            e = step_ctl(st);
            if (st == 1 && !mr) begin e.pc_write = 0; e.ir_write = 0; end
            if (st == 6 && !mr) e.instr_done = 0;
            if (st == 7) e.alu_op = r_alu(cur_funct);
            e.illegal = model_illegal;
            e.state   = 4'(st);
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_stage(input int st, input int waits);
        for (int i = 0; i < waits; i++) drive_cycle(st, 1'b0, 1'b0);
        drive_cycle(st, 1'b1, 1'b0);
    endtask

    task automatic reset_pulse();
        drive_cycle(0, 1'($urandom_range(0, 1)), 1'b1);
        drive_cycle(0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    // kind: 0 LW 1 SW 2 J 3 JAL 4 JR 5 BNE 6 XORI 7 ADD 8 SUB 9 SLT 10 illegal
    task automatic run_instr(input int kind, input int fw, input int mw, input logic [5:0] bad_op);
        bit r;
        case (kind)
            0: begin cur_op = 6'h23; cur_funct = 6'($urandom); end
            1: begin cur_op = 6'h2B; cur_funct = 6'($urandom); end
            2: begin cur_op = 6'h02; cur_funct = 6'($urandom); end
            3: begin cur_op = 6'h03; cur_funct = 6'($urandom); end
            4: begin cur_op = 6'h00; cur_funct = 6'h08; end
            5: begin cur_op = 6'h05; cur_funct = 6'($urandom); end
            6: begin cur_op = 6'h0E; cur_funct = 6'($urandom); end
            7: begin cur_op = 6'h00; cur_funct = 6'h20; end
            8: begin cur_op = 6'h00; cur_funct = 6'h22; end
            9: begin cur_op = 6'h00; cur_funct = 6'h2A; end
            default: begin
                cur_op = bad_op;
                cur_funct = (bad_op == 6'h00) ? 6'h21 : 6'($urandom);
            end
        endcase
        wait_stage(1, fw);
        r = 1'($urandom_range(0, 1));
        drive_cycle(2, r, 1'b0);
        case (kind)
            0: begin drive_cycle(3, 1'($urandom), 1'b0); wait_stage(4, mw);
                     drive_cycle(5, 1'($urandom), 1'b0); end
            1: begin drive_cycle(3, 1'($urandom), 1'b0); wait_stage(6, mw); end
            2: drive_cycle(12, 1'($urandom), 1'b0);
            3: drive_cycle(13, 1'($urandom), 1'b0);
            4: drive_cycle(14, 1'($urandom), 1'b0);
            5: drive_cycle(11, 1'($urandom), 1'b0);
            6: begin drive_cycle(9, 1'($urandom), 1'b0); drive_cycle(10, 1'($urandom), 1'b0); end
            7, 8, 9: begin drive_cycle(7, 1'($urandom), 1'b0); drive_cycle(8, 1'($urandom), 1'b0); end
            default: model_illegal = 1'b1;
        endcase
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Every cycle the DUT presents a full control word; check it mid-cycle.
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        cyc++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read_enable,
                   mem_write_enable, ir_write, alu_src_a, alu_src_b, alu_op,
                   reg_write_enable, reg_dest, mem_to_reg, instr_done, illegal, state};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL ctl_word cyc=%0d got=%h exp=%h (state got=%0d exp=%0d)",
                         cyc, got, exp, got[3:0], exp[3:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [5:0] bad_ops[5] = '{6'h3F, 6'h04, 6'h08, 6'h0F, 6'h00};

    initial begin
        // Power-on reset, then reset landing in the middle of a LW wait.
        reset_pulse();
        cur_op = 6'h23;
        drive_cycle(1, 1'b1, 1'b0);
        drive_cycle(2, 1'b1, 1'b0);
        drive_cycle(3, 1'b1, 1'b0);
        drive_cycle(4, 1'b0, 1'b0);
        reset_pulse();
        // Directed sequence from the test plan.
        run_instr(7, 0, 0, 6'h3F);   // ADD
        run_instr(0, 0, 2, 6'h3F);   // LW with two wait cycles
        run_instr(5, 0, 0, 6'h3F);   // BNE
        run_instr(5, 1, 0, 6'h3F);
        run_instr(3, 0, 0, 6'h3F);   // JAL
        run_instr(4, 0, 0, 6'h3F);   // JR
        run_instr(1, 2, 1, 6'h3F);   // SW with stalls
        run_instr(10, 0, 0, 6'h3F);  // illegal 0x3F
        run_instr(6, 0, 0, 6'h3F);   // XORI with illegal still set
        reset_pulse();
        run_instr(6, 0, 0, 6'h3F);
        // Random streams.
        for (int n = 0; n < 300; n++) begin
            int k;
            k = $urandom_range(0, 10);
            run_instr(k, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
                      $urandom_range(0, 2), bad_ops[$urandom_range(0, 4)]);
            if ($urandom_range(0, 40) == 0) reset_pulse();
        end
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d left exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the stimulus is bounded, so this only fires on a stuck bench.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control state machine for the multi-cycle MIPS datapath variant. It sequences a shared ALU, a single unified instruction/data memory, the PC register, IR, MDR, the A/B/ALUOut registers and the register file through fetch, decode, execute, memory and writeback. It also handles a memory wait handshake. It supports LW, SW, J, JAL, JR, BNE, XORI, ADD, SUB and SLT.

## Interface
- No parameters.
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- op  in  6  IR[31:26], sampled in DECODE
- funct  in  6  IR[5:0], sampled in DECODE
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load only if zero==0 (BNE)
- pc_src  out  2  0 ALU result, 1 ALUOut, 2 {PC[31:28],IR[25:0],2'b00}, 3 reg A
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read_enable  out  1  memory read request
- mem_write_enable  out  1  memory write request
- ir_write  out  1  IR load
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  3  0 reg B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2, 4 zero-ext imm
- alu_op  out  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
- reg_write_enable  out  1  register file write
- reg_dest  out  2  0 rt, 1 rd, 2 r31
- mem_to_reg  out  2  0 ALUOut, 1 MDR, 2 PC
- instr_done  out  1  final cycle of a retired instruction
- illegal  out  1  sticky: unsupported op/funct decoded
- state  out  4  current state encoding (debug)

## Operation
- States, encoded as follows: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, BRANCH=11, JUMP=12, JAL=13, JR=14.
- Moore outputs are decoded from the state. Any control not listed for a state is 0. The only exception is gating by mem_ready where stated.
- IDLE: all outputs 0. Always goes to FETCH next cycle.
- FETCH: i_or_d=0, mem_read_enable=1, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0. pc_write and ir_write are asserted only when mem_ready=1. Holds in FETCH while mem_ready=0, otherwise goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD, which leaves the branch target in ALUOut. Next state by op:
  - 0x23 or 0x2B → MEM_ADDR
  - 0x00 with funct 0x20/0x22/0x2A → R_EXEC
  - 0x00 with funct 0x08 → JR
  - 0x0E → I_EXEC
  - 0x05 → BRANCH
  - 0x02 → JUMP
  - 0x03 → JAL
  - anything else → set illegal, go to FETCH; no instr_done, PC already advanced.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. Goes to MEM_READ if op=0x23, else MEM_WRITE.
- MEM_READ: i_or_d=1, mem_read_enable=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write_enable=1, reg_dest=0, mem_to_reg=1, instr_done=1. Goes to FETCH.
- MEM_WRITE: i_or_d=1, mem_write_enable=1. Holds until mem_ready. instr_done=mem_ready. Then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op from funct (0x20 ADD, 0x22 SUB, 0x2A SLT). Goes to R_WB.
- R_WB: reg_write_enable=1, reg_dest=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=4, alu_op=XOR. Goes to I_WB.
- I_WB: reg_write_enable=1, reg_dest=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_write_cond=1, pc_src=1, instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_src=2, instr_done=1. Goes to FETCH.
- JAL: pc_write=1, pc_src=2, reg_write_enable=1, reg_dest=2, mem_to_reg=2, instr_done=1. r31 receives the PC value before the jump, which is the old PC+4. Goes to FETCH.
- JR: pc_write=1, pc_src=3, instr_done=1. Goes to FETCH.
- illegal: cleared only by reset.
- Registered encodings: state and illegal are registers; op and funct are never registered here.

## Timing
- Reset asserted, at any time including mid-wait: next state is IDLE immediately (asynchronous). All outputs read 0, illegal=0, state=0. The first FETCH is the first cycle after reset deasserts.
- Cycles with mem_ready=1 every time:
  - 3 cycles: J, JAL, JR, BNE
  - 4 cycles: R-type, XORI, SW
  - 5 cycles: LW
  - Each wait cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds 1 cycle.
- During wait cycles all outputs hold steady. pc_write, ir_write and mem-stage instr_done stay 0 until the cycle in which mem_ready=1.
- BNE: PC is written in the BRANCH cycle when zero==0 at that edge. When zero==1, PC keeps its FETCH-incremented value.
- mem_ready is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

## Test plan
- Reset: reset=1 mid-MEM_READ → state=0 and all outputs 0 same cycle. After release: cycle 1 state=1, mem_read_enable=1.
- ADD (op 0x00, funct 0x20), mem_ready=1: states 1,2,7,8. R_EXEC alu_op=000. R_WB reg_write_enable=1, reg_dest=1, instr_done=1.
- LW (0x23) with mem_ready low for 2 cycles in MEM_READ: states 1,2,3,4,4,4,5. mem_read_enable=1 and i_or_d=1 held for 3 cycles. MEM_WB mem_to_reg=1.
- BNE (0x05): with zero=0 in BRANCH, pc_write_cond=1, pc_src=1. With zero=1, same outputs and instr_done=1. Total 3 cycles.
- JAL (0x03): JAL state gives pc_write=1, pc_src=2, reg_dest=2, mem_to_reg=2. Then JR (funct 0x08) gives pc_src=3.
- Illegal op 0x3F: DECODE → FETCH, illegal=1 and stays 1 through a following XORI (0x0E, alu_src_b=4, alu_op=010). Reset clears it.
